// File: rtl/hs4_responder_if.sv
// Four-phase bundled-data receive link plus the local valid/ready delivery port.
// The master side is the initiator/local logic; the responder uses the slave side.
interface hs4_responder_if #(
    parameter int DW = 8
);
    logic          req_i;
    logic [DW-1:0] data_i;
    logic          ack_o;
    logic          out_valid_o;
    logic          out_ready_i;
    logic [DW-1:0] out_data_o;
    logic          busy_o;
    logic          proto_err_o;
    logic          err_clr_i;

    modport master (
        output req_i,
        output data_i,
        output out_ready_i,
        output err_clr_i,
        input  ack_o,
        input  out_valid_o,
        input  out_data_o,
        input  busy_o,
        input  proto_err_o
    );

    modport slave (
        input  req_i,
        input  data_i,
        input  out_ready_i,
        input  err_clr_i,
        output ack_o,
        output out_valid_o,
        output out_data_o,
        output busy_o,
        output proto_err_o
    );
endinterface

// File: rtl/hs4_responder.sv
// Responder end of a four-phase req/ack bundled-data link: synchronises req,
// captures the word, hands it to local logic, then runs the return-to-zero ack.
module hs4_responder #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int ACK_DELAY   = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    hs4_responder_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DELIVER = 2'd1,
        WAIT    = 2'd2,
        ACK_UP  = 2'd3
    } state_t;

    localparam int            CW       = 4;
    localparam logic [CW-1:0] DELAY_LD = CW'(ACK_DELAY);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   req_s;
    logic [CW-1:0]          cnt_r;
    logic [CW-1:0]          cnt_nxt_s;
    logic                   ack_r;
    logic                   ack_nxt_s;
    logic                   valid_r;
    logic                   valid_nxt_s;
    logic [DW-1:0]          data_r;
    logic [DW-1:0]          data_nxt_s;
    logic                   busy_r;
    logic                   err_r;
    logic                   err_nxt_s;
    logic                   abort_r;
    logic                   abort_nxt_s;
    logic                   viol_s;
    logic                   fire_s;

    assign req_s = sync_r[SYNC_STAGES-1];

    // Request synchroniser chain; data_i is only looked at once req_s is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], bus.req_i};
        end
    end

    // Next-state and next-output logic for the handshake sequencer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        ack_nxt_s   = ack_r;
        valid_nxt_s = valid_r;
        data_nxt_s  = data_r;
        abort_nxt_s = abort_r;
        viol_s      = 1'b0;
        fire_s      = valid_r & bus.out_ready_i;

        case (state_r)
            IDLE: begin
                abort_nxt_s = 1'b0;
                ack_nxt_s   = 1'b0;
                if (req_s) begin
                    data_nxt_s  = bus.data_i;
                    valid_nxt_s = 1'b1;
                    state_nxt_s = DELIVER;
                end else begin
                    valid_nxt_s = 1'b0;
                    state_nxt_s = IDLE;
                end
            end

            DELIVER: begin
                // The initiator must hold req until it sees ack.
                viol_s      = ~req_s;
                abort_nxt_s = abort_r | viol_s;
                if (fire_s) begin
                    valid_nxt_s = 1'b0;
                    if (ACK_DELAY > 0) begin
                        cnt_nxt_s   = DELAY_LD;
                        state_nxt_s = WAIT;
                    end else if (abort_nxt_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        ack_nxt_s   = 1'b1;
                        state_nxt_s = ACK_UP;
                    end
                end else begin
                    valid_nxt_s = 1'b1;
                end
            end

            WAIT: begin
                viol_s      = ~req_s;
                abort_nxt_s = abort_r | viol_s;
                if (cnt_r <= 4'd1) begin
                    cnt_nxt_s = 4'd0;
                    if (abort_nxt_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        ack_nxt_s   = 1'b1;
                        state_nxt_s = ACK_UP;
                    end
                end else begin
                    cnt_nxt_s = cnt_r - 4'd1;
                end
            end

            ACK_UP: begin
                if (!req_s) begin
                    ack_nxt_s   = 1'b0;
                    state_nxt_s = IDLE;
                end else begin
                    ack_nxt_s   = 1'b1;
                end
            end

            default: begin
                ack_nxt_s   = 1'b0;
                valid_nxt_s = 1'b0;
                abort_nxt_s = 1'b0;
                cnt_nxt_s   = 4'd0;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Sticky protocol error: a fresh violation beats a simultaneous clear.
    always_comb begin
        err_nxt_s = err_r;
        if (viol_s) begin
            err_nxt_s = 1'b1;
        end else if (bus.err_clr_i) begin
            err_nxt_s = 1'b0;
        end else begin
            err_nxt_s = err_r;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            ack_r   <= 1'b0;
            valid_r <= 1'b0;
            data_r  <= {DW{1'b0}};
            busy_r  <= 1'b0;
            err_r   <= 1'b0;
            abort_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            ack_r   <= ack_nxt_s;
            valid_r <= valid_nxt_s;
            data_r  <= data_nxt_s;
            busy_r  <= (state_nxt_s != IDLE);
            err_r   <= err_nxt_s;
            abort_r <= abort_nxt_s;
        end
    end

    assign bus.ack_o       = ack_r;
    assign bus.out_valid_o = valid_r;
    assign bus.out_data_o  = data_r;
    assign bus.busy_o      = busy_r;
    assign bus.proto_err_o = err_r;
endmodule
